// File: rtl/wb_sevenseg_if.sv
// Wishbone classic bus bundle between the conbus slave port and the seven-segment scanner.
interface wb_sevenseg_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_sevenseg_scan.sv
// Wishbone slave that scans a 4-digit common-anode seven-segment display.
// Define SEVENSEG_DIM_EN to add PWM brightness control through the DIM register.
module wb_sevenseg_scan #(
    parameter int clk_freq = 50000000,
    parameter int scan_hz  = 1000
) (
    input  logic         clk,
    input  logic         reset,
    wb_sevenseg_if.slave wb,
    output logic [6:0]   seg,
    output logic         dp,
    output logic [3:0]   an
);
    localparam int DIVIDER = clk_freq / scan_hz;
    localparam int PW      = $clog2(DIVIDER);
    localparam logic [PW-1:0] PRE_RELOAD = PW'(DIVIDER - 1);

    localparam logic [31:0] DATA_MASK = 32'h0000_FFFF;
    localparam logic [31:0] CTRL_MASK = 32'h0000_0FF3;
`ifdef SEVENSEG_DIM_EN
    localparam logic [31:0] DIM_MASK  = 32'h0000_000F;
    localparam logic [31:0] DIM_RESET = 32'h0000_000F;
`else
    localparam logic [31:0] DIM_MASK  = 32'h0000_0000;
    localparam logic [31:0] DIM_RESET = 32'h0000_0000;
`endif

    logic [31:0]   data_reg, ctrl_reg, raw_reg, dim_reg;
    logic [31:0]   data_next, ctrl_next, raw_next, dim_next;
    logic [31:0]   rd_data, lane_mask, wr_merge;
    logic [31:0]   dat_o_reg;
    logic          ack_reg;
    logic [PW-1:0] prescaler_reg;
    logic [1:0]    digit_reg;
    logic [6:0]    seg_reg;
    logic          dp_reg;
    logic [3:0]    an_reg;
    logic [3:0]    nibble   [4];
    logic [7:0]    raw_byte [4];
    logic [7:0]    pattern;
    logic          bus_req, wr_commit, run;
    logic [1:0]    reg_sel;
    logic          unused_adr_bits;

    function automatic logic [6:0] font(input logic [3:0] v);
        case (v)
            4'h0: font = 7'h40;
            4'h1: font = 7'h79;
            4'h2: font = 7'h24;
            4'h3: font = 7'h30;
            4'h4: font = 7'h19;
            4'h5: font = 7'h12;
            4'h6: font = 7'h02;
            4'h7: font = 7'h78;
            4'h8: font = 7'h00;
            4'h9: font = 7'h10;
            4'hA: font = 7'h08;
            4'hB: font = 7'h03;
            4'hC: font = 7'h46;
            4'hD: font = 7'h21;
            4'hE: font = 7'h06;
            default: font = 7'h0E;
        endcase
    endfunction

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_mask[8*gi +: 8] = {8{wb.wb_sel_i[gi]}};
            assign nibble[gi]           = data_reg[4*gi +: 4];
            assign raw_byte[gi]         = raw_reg[8*gi +: 8];
        end
    endgenerate

    assign bus_req         = wb.wb_stb_i & wb.wb_cyc_i;
    assign wr_commit       = ack_reg & bus_req & wb.wb_we_i;
    assign reg_sel         = wb.wb_adr_i[3:2];
    assign unused_adr_bits = ^{wb.wb_adr_i[31:4], wb.wb_adr_i[1:0]};

    always_comb begin
        data_next = data_reg;
        ctrl_next = ctrl_reg;
        raw_next  = raw_reg;
        dim_next  = dim_reg;
        wr_merge  = 32'h0;
        if (wr_commit) begin
            case (reg_sel)
                2'd0: begin
                    wr_merge  = (data_reg & ~lane_mask) | (wb.wb_dat_i & lane_mask);
                    data_next = wr_merge & DATA_MASK;
                end
                2'd1: begin
                    wr_merge  = (ctrl_reg & ~lane_mask) | (wb.wb_dat_i & lane_mask);
                    ctrl_next = wr_merge & CTRL_MASK;
                end
                2'd2: begin
                    wr_merge = (raw_reg & ~lane_mask) | (wb.wb_dat_i & lane_mask);
                    raw_next = wr_merge;
                end
                default: begin
                    wr_merge = (dim_reg & ~lane_mask) | (wb.wb_dat_i & lane_mask);
                    dim_next = wr_merge & DIM_MASK;
                end
            endcase
        end
    end

    always_comb begin
        case (reg_sel)
            2'd0:    rd_data = data_reg;
            2'd1:    rd_data = ctrl_reg;
            2'd2:    rd_data = raw_reg;
            default: rd_data = dim_reg;
        endcase
    end

    // {dp_n, seg} for the digit about to be shown, sampled only on the tick
    assign pattern = ctrl_reg[1] ? raw_byte[digit_reg]
                                 : {~ctrl_reg[4 + int'(digit_reg)], font(nibble[digit_reg])};

    // Clearing enable blanks at once; setting it waits for the register to settle
    assign run = ctrl_reg[0] & ctrl_next[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_reg       <= 1'b0;
            dat_o_reg     <= 32'h0;
            data_reg      <= 32'h0;
            ctrl_reg      <= 32'h1;
            raw_reg       <= 32'hFFFF_FFFF;
            dim_reg       <= DIM_RESET;
            prescaler_reg <= PRE_RELOAD;
            digit_reg     <= 2'd0;
            seg_reg       <= 7'h7F;
            dp_reg        <= 1'b1;
            an_reg        <= 4'hF;
        end else begin
            ack_reg   <= bus_req & ~ack_reg;
            dat_o_reg <= (bus_req & ~ack_reg) ? rd_data : 32'h0;
            data_reg  <= data_next;
            ctrl_reg  <= ctrl_next;
            raw_reg   <= raw_next;
            dim_reg   <= dim_next;
            if (!run) begin
                prescaler_reg <= PRE_RELOAD;
                digit_reg     <= 2'd0;
                seg_reg       <= 7'h7F;
                dp_reg        <= 1'b1;
                an_reg        <= 4'hF;
            end else if (prescaler_reg == '0) begin
                prescaler_reg <= PRE_RELOAD;
                digit_reg     <= digit_reg + 2'd1;
                seg_reg       <= pattern[6:0];
                dp_reg        <= pattern[7];
                an_reg        <= ctrl_reg[8 + int'(digit_reg)] ? 4'hF : ~(4'b0001 << digit_reg);
            end else begin
                prescaler_reg <= prescaler_reg - PW'(1);
                // dead-time cycle sits in the last count of every slot
                if (prescaler_reg == PW'(1)) begin
                    an_reg <= 4'hF;
                end
            end
        end
    end

`ifdef SEVENSEG_DIM_EN
    logic [3:0] pwm_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_reg <= 4'd0;
        end else begin
            pwm_reg <= pwm_reg + 4'd1;
        end
    end

    assign an = an_reg | {4{pwm_reg >= dim_reg[3:0]}};
`else
    assign an = an_reg;
`endif

    assign seg         = seg_reg;
    assign dp          = dp_reg;
    assign wb.wb_ack_o = ack_reg;
    assign wb.wb_dat_o = dat_o_reg;
endmodule

// File: tb/tb_wb_sevenseg_scan.sv
// Directed bench for wb_sevenseg_scan with a 10-cycle slot (clk_freq 1000, scan_hz 100).
module tb_wb_sevenseg_scan;
    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    int errors = 0;
    int checks = 0;

    wb_sevenseg_if bus ();

    wb_sevenseg_scan #(.clk_freq(1000), .scan_hz(100)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (bus),
        .seg   (seg),
        .dp    (dp),
        .an    (an)
    );

    always #5 clk = ~clk;

`ifdef SEVENSEG_DIM_EN
    logic [3:0] pwm_m;
    logic [3:0] dim_m = 4'd15;
    always @(posedge clk) pwm_m <= reset ? 4'd0 : pwm_m + 4'd1;
`endif

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dsel;
        logic [31:0] ctrl;
        logic [31:0] raw;
        logic [15:0] data_rd;
        logic [11:0] ctrl_rd;
        logic [27:0] segs;
        logic [3:0]  dps;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] lit_an(input int slot);
        logic [3:0] one = 4'b0001;
        logic gate;
`ifdef SEVENSEG_DIM_EN
        gate = (pwm_m < dim_m);
`else
        gate = 1'b1;
`endif
        return gate ? ~(one << slot) : 4'hF;
    endfunction

    task automatic bus_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        bus.wb_adr_i = adr; bus.wb_dat_i = dat; bus.wb_sel_i = sel;
        bus.wb_we_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_cyc_i = 1'b1;
        @(negedge clk);
        check("wr_ack", {31'd0, bus.wb_ack_o}, 32'd1);
        @(negedge clk);
        check("wr_ack_single", {31'd0, bus.wb_ack_o}, 32'd0);
        bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_we_i = 1'b0;
        $display("write adr=%h dat=%h sel=%b", adr, dat, sel);
    endtask

    task automatic bus_read(input logic [31:0] adr, input logic [31:0] exp, input string name);
        logic [31:0] got;
        bus.wb_adr_i = adr; bus.wb_sel_i = 4'hF;
        bus.wb_we_i = 1'b0; bus.wb_stb_i = 1'b1; bus.wb_cyc_i = 1'b1;
        @(negedge clk);
        check("rd_ack", {31'd0, bus.wb_ack_o}, 32'd1);
        got = bus.wb_dat_o;
        check(name, got, exp);
        @(negedge clk);
        check("rd_ack_single", {31'd0, bus.wb_ack_o}, 32'd0);
        check("rd_dat_idle", bus.wb_dat_o, 32'd0);
        bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0;
        $display("read  adr=%h dat=%h", adr, got);
    endtask

    // Called on the first cycle with the scan freshly (re)enabled
    task automatic check_frame(input logic [27:0] segs, input logic [3:0] dps,
                               input logic [3:0] blank, input int slots);
        for (int k = 1; k <= 10 * (slots + 1); k++) begin
            @(negedge clk);
            if (k < 10) begin
                check("an_startup", {28'd0, an}, 32'hF);
            end else begin
                int j;
                int slot;
                int pos;
                j = k - 10;
                slot = (j / 10) % 4;
                pos = j % 10;
                if (pos == 9 || blank[slot])
                    check($sformatf("an_dark_d%0d", slot), {28'd0, an}, 32'hF);
                else
                    check($sformatf("an_lit_d%0d", slot), {28'd0, an}, {28'd0, lit_an(slot)});
                if (pos == 0 && !blank[slot]) begin
                    check($sformatf("seg_d%0d", slot), {25'd0, seg}, {25'd0, segs[7*slot +: 7]});
                    check($sformatf("dp_d%0d", slot), {31'd0, dp}, {31'd0, dps[slot]});
                end
            end
        end
    endtask

    task automatic resync(input logic [31:0] ctrl);
        bus_write(32'h4, ctrl & ~32'h1, 4'hF);
        bus_write(32'h4, ctrl, 4'hF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'h0000, 4'hF,    32'h0000_0001, 32'hFFFF_FFFF, 16'h0000, 12'h001,
                    {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111};
        vecs[1] = '{16'h1234, 4'b0011, 32'h0000_0001, 32'hFFFF_FFFF, 16'h1234, 12'h001,
                    {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
        vecs[2] = '{16'h5678, 4'b0010, 32'h0000_00A1, 32'hFFFF_FFFF, 16'h5634, 12'h0A1,
                    {7'h12, 7'h02, 7'h30, 7'h19}, 4'b0101};
        vecs[3] = '{16'h1234, 4'hF,    32'h0000_0401, 32'hFFFF_FFFF, 16'h1234, 12'h401,
                    {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
        vecs[4] = '{16'h89EF, 4'hF,    32'hFFFF_F0AD, 32'hFFFF_FFFF, 16'h89EF, 12'h0A1,
                    {7'h00, 7'h10, 7'h06, 7'h0E}, 4'b0101};
        vecs[5] = '{16'h0000, 4'h0,    32'h0000_0003, 32'h7F7F_7F00, 16'h89EF, 12'h003,
                    {7'h7F, 7'h7F, 7'h7F, 7'h00}, 4'b0000};
        vecs[6] = '{16'h0000, 4'h0,    32'h0000_00F3, 32'h8024_FF79, 16'h89EF, 12'h0F3,
                    {7'h00, 7'h24, 7'h7F, 7'h79}, 4'b1010};
        vecs[7] = '{16'hABCD, 4'hF,    32'h0000_09A1, 32'hFFFF_FFFF, 16'hABCD, 12'h9A1,
                    {7'h08, 7'h03, 7'h46, 7'h21}, 4'b0101};
        vecs[8] = '{16'h5670, 4'hF,    32'h0000_00F1, 32'hFFFF_FFFF, 16'h5670, 12'h0F1,
                    {7'h12, 7'h02, 7'h78, 7'h40}, 4'b0000};

        bus.wb_adr_i = 32'h0; bus.wb_dat_i = 32'h0; bus.wb_sel_i = 4'h0;
        bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_we_i = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_dp", {31'd0, dp}, 32'd1);
        check("rst_ack", {31'd0, bus.wb_ack_o}, 32'd0);
        check("rst_dat_o", bus.wb_dat_o, 32'd0);
        reset = 1'b0;
        $display("reset released");
        check_frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 4'h0, 4);
        bus_read(32'h4, 32'h1, "rst_ctrl");
        bus_read(32'h0, 32'h0, "rst_data");
        bus_read(32'h8, 32'hFFFF_FFFF, "rst_raw");
`ifdef SEVENSEG_DIM_EN
        bus_read(32'hC, 32'hF, "rst_dim");
`else
        bus_read(32'hC, 32'h0, "rst_dim");
`endif

        for (int v = 0; v < 9; v++) begin
            $display("vector %0d data=%h ctrl=%h raw=%h", v, vecs[v].data, vecs[v].ctrl, vecs[v].raw);
            bus_write(32'h0, {16'hBEEF, vecs[v].data}, vecs[v].dsel);
            bus_write(32'h8, vecs[v].raw, 4'hF);
            bus_write(32'h4, vecs[v].ctrl & ~32'h1, 4'hF);
            bus_read(32'h0, {16'd0, vecs[v].data_rd}, "data_rd");
            bus_read(32'h4, {20'd0, vecs[v].ctrl_rd & 12'hFFE}, "ctrl_rd");
            bus_read(32'h8, vecs[v].raw, "raw_rd");
            bus_write(32'h4, vecs[v].ctrl, 4'hF);
            check_frame(vecs[v].segs, vecs[v].dps, vecs[v].ctrl_rd[11:8], 4);
        end

        // Disable mid-slot blanks on the following cycle; re-enable lights digit 0 after a full slot
        repeat (3) @(negedge clk);
        bus_write(32'h4, 32'h0, 4'hF);
        check("dis_an", {28'd0, an}, 32'hF);
        repeat (2) @(negedge clk);
        check("dis_an_hold", {28'd0, an}, 32'hF);
        check("dis_seg", {25'd0, seg}, 32'h7F);
        check("dis_dp", {31'd0, dp}, 32'd1);
        bus_write(32'h4, 32'h1, 4'hF);
        check_frame({7'h12, 7'h02, 7'h78, 7'h40}, 4'hF, 4'h0, 1);

        // Write committing on the tick edge: the tick keeps the old digit-0 value
        resync(32'h1);
        repeat (8) @(negedge clk);
        bus_write(32'h0, 32'h0000_0008, 4'hF);
        check("tick_old_an", {28'd0, an}, {28'd0, lit_an(0)});
        check("tick_old_seg", {25'd0, seg}, 32'h40);
        repeat (40) @(negedge clk);
        check("tick_new_seg", {25'd0, seg}, 32'h00);

        // Raw mode, then reset in the middle of a slot and of a bus cycle
        bus_write(32'h8, 32'h7F7F_7F00, 4'hF);
        resync(32'h3);
        check_frame({7'h7F, 7'h7F, 7'h7F, 7'h00}, 4'h0, 4'h0, 1);
        repeat (2) @(negedge clk);
        bus.wb_adr_i = 32'h0; bus.wb_dat_i = 32'h0000_FFFF; bus.wb_sel_i = 4'hF;
        bus.wb_we_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_cyc_i = 1'b1;
        @(negedge clk);
        check("rstmid_ack", {31'd0, bus.wb_ack_o}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rstmid_ack_drop", {31'd0, bus.wb_ack_o}, 32'd0);
        check("rstmid_an", {28'd0, an}, 32'hF);
        check("rstmid_seg", {25'd0, seg}, 32'h7F);
        check("rstmid_dp", {31'd0, dp}, 32'd1);
        bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_we_i = 1'b0;
        reset = 1'b0;
        $display("reset pulsed mid-slot");
`ifdef SEVENSEG_DIM_EN
        dim_m = 4'd15;
`endif
        bus_read(32'h4, 32'h1, "rstmid_ctrl");
        bus_read(32'h0, 32'h0, "rstmid_data");
        bus_read(32'h8, 32'hFFFF_FFFF, "rstmid_raw");

        // cyc without stb must neither ack nor write
        bus.wb_adr_i = 32'h0; bus.wb_dat_i = 32'h0000_FFFF; bus.wb_sel_i = 4'hF;
        bus.wb_we_i = 1'b1; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("nostb_ack", {31'd0, bus.wb_ack_o}, 32'd0);
        end
        bus.wb_cyc_i = 1'b0; bus.wb_we_i = 1'b0;
        $display("cyc without stb held 3 cycles");
        bus_read(32'h0, 32'h0, "nostb_data");

        // Brightness register
        bus_write(32'hC, 32'h0000_0004, 4'hF);
`ifdef SEVENSEG_DIM_EN
        dim_m = 4'd4;
        bus_read(32'hC, 32'h4, "dim_rd");
`else
        bus_read(32'hC, 32'h0, "dim_rd");
`endif
        resync(32'h1);
        check_frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 4'h0, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
